// File: rtl/exponent_normalize_left.sv
// exponent_normalize_left
// Sequential left-normalizer for single-precision mantissa/exponent pairs.
// Each cycle in SHIFT moves the mantissa left one place and decrements the
// exponent, until the hidden bit is set, the mantissa is zero, or the exponent
// floor is reached. Upstream and downstream use valid/ready handshakes.
//
// Build option: define EXP_NORM_DENORM_EN to make the exponent floor produce
// a denormal (the partially shifted mantissa, exponent 0). When it is not
// defined, the floor flushes the result to zero with the sign preserved.
module exponent_normalize_left #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_underflow
);

`ifdef EXP_NORM_DENORM_EN
    localparam bit DENORM_EN = 1'b1;
`else
    localparam bit DENORM_EN = 1'b0;
`endif

    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    // Working copy of the operand while it is being normalized
    logic              sign_w;
    logic [EXP_W-1:0]  exp_w;
    logic [MANT_W-1:0] mant_w;

    logic mant_is_zero;
    logic hidden_set;
    logic at_floor;
    logic do_shift;

    assign mant_is_zero = (mant_w == '0);
    assign hidden_set   = mant_w[MANT_W-1];
    assign at_floor     = (exp_w <= EXP_ONE);
    assign do_shift     = (state == SHIFT) && !mant_is_zero && !hidden_set && !at_floor;

    // Operand working registers: load on accept, shift/decrement while normalizing
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            sign_w <= in_sign;
            exp_w  <= in_exp;
            mant_w <= in_mant;
        end else if (do_shift) begin
            mant_w <= {mant_w[MANT_W-2:0], 1'b0};
            exp_w  <= exp_w - EXP_ONE;
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_sign      <= 1'b0;
            out_exp       <= '0;
            out_mant      <= '0;
            out_zero      <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (mant_is_zero) begin
                        state         <= DONE;
                        out_valid     <= 1'b1;
                        out_sign      <= sign_w;
                        out_exp       <= '0;
                        out_mant      <= '0;
                        out_zero      <= 1'b1;
                        out_underflow <= 1'b0;
                    end else if (hidden_set) begin
                        // Already normalized: exponent passes through, even when 0
                        state         <= DONE;
                        out_valid     <= 1'b1;
                        out_sign      <= sign_w;
                        out_exp       <= exp_w;
                        out_mant      <= mant_w;
                        out_zero      <= 1'b0;
                        out_underflow <= 1'b0;
                    end else if (at_floor) begin
                        // Exponent floor reached before the hidden bit appeared
                        state         <= DONE;
                        out_valid     <= 1'b1;
                        out_sign      <= sign_w;
                        out_exp       <= '0;
                        out_mant      <= DENORM_EN ? mant_w : '0;
                        out_zero      <= !DENORM_EN;
                        out_underflow <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exponent_normalize_left.sv
// tb_exponent_normalize_left
// Directed bench for exponent_normalize_left. Expected results are queued when
// an operand is accepted and compared when the result handshake comes up.
// Honors EXP_NORM_DENORM_EN the same way as the design.
module tb_exponent_normalize_left;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        z;
        logic        u;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [23:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;
    logic        out_zero;
    logic        out_underflow;

    int   nassert = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];
    exp_t dropped;

    exponent_normalize_left dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_mant     (out_mant),
        .out_zero     (out_zero),
        .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nassert++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioral reference: walk the normalization one step at a time
    function automatic exp_t model(input logic s, input logic [7:0] e, input logic [23:0] m);
        exp_t r;
        int   shifts;
        logic done;
        r = '0;
        r.s = s;
        shifts = 0;
        done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!done) begin
                if (m == 24'd0) begin
                    e = 8'd0; r.z = 1'b1; done = 1'b1;
                end else if (m[23]) begin
                    done = 1'b1;
                end else if (e <= 8'd1) begin
                    r.u = 1'b1;
                    e = 8'd0;
`ifndef EXP_NORM_DENORM_EN
                    m = 24'd0;
                    r.z = 1'b1;
`endif
                    done = 1'b1;
                end else begin
                    m = m << 1;
                    e = e - 8'd1;
                    shifts++;
                end
            end
        end
        r.e = e;
        r.m = m;
        r.lat = 8'(shifts + 2);
        return r;
    endfunction

    function automatic exp_t mk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                input logic z, input logic u, input logic [7:0] lat);
        exp_t r;
        r.s = s; r.e = e; r.m = m; r.z = z; r.u = u; r.lat = lat;
        return r;
    endfunction

    // Present an operand; when sync is 0 the caller is already at a falling edge
    task automatic send(input bit sync, input logic s, input logic [7:0] e,
                        input logic [23:0] m, input exp_t want);
        if (sync) @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        sb.push_back(want);
    endtask

    task automatic compare_out(input string tag, input exp_t w);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_sign"}, 32'(out_sign), 32'(w.s));
        check({tag, "_exp"}, 32'(out_exp), 32'(w.e));
        check({tag, "_mant"}, 32'(out_mant), 32'(w.m));
        check({tag, "_zero"}, 32'(out_zero), 32'(w.z));
        check({tag, "_uf"}, 32'(out_underflow), 32'(w.u));
    endtask

    // Wait (bounded) for the result, compare, optionally stall, then handshake
    task automatic receive(input string tag, input int hold);
        bit   got;
        exp_t w;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!got) begin
                @(negedge clk);
                if (out_valid) got = 1'b1;
            end
        end
        check({tag, "_timeout"}, 32'(got), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (got && sb.size() > 0) begin
            w = sb.pop_front();
            check({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(w.lat));
            compare_out(tag, w);
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                compare_out({tag, "_hold"}, w);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
            check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [7:0]  re;
        logic [23:0] rm;
        logic        rs;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outs", {6'd0, out_sign, out_zero, out_underflow, out_exp, out_mant[14:0]}, 32'd0);
        check("rst_mant", 32'(out_mant), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Already normalized, sign carried through
        send(1, 1'b1, 8'h80, 24'h800000, mk(1'b1, 8'h80, 24'h800000, 1'b0, 1'b0, 8'd2));
        receive("norm", 0);

        // 23 leading zeros
        send(1, 1'b0, 8'h80, 24'h000001, mk(1'b0, 8'h69, 24'h800000, 1'b0, 1'b0, 8'd25));
        receive("k23", 0);

        // Zero mantissa
        send(1, 1'b0, 8'h55, 24'h000000, mk(1'b0, 8'h00, 24'h000000, 1'b1, 1'b0, 8'd2));
        receive("zero", 0);

        // Hidden bit set with exponent 0: exponent stays 0, no underflow
        send(1, 1'b1, 8'h00, 24'hC00001, mk(1'b1, 8'h00, 24'hC00001, 1'b0, 1'b0, 8'd2));
        receive("exp0_norm", 0);

        // Floor after two shifts
`ifdef EXP_NORM_DENORM_EN
        send(1, 1'b0, 8'h03, 24'h100000, mk(1'b0, 8'h00, 24'h400000, 1'b0, 1'b1, 8'd4));
`else
        send(1, 1'b0, 8'h03, 24'h100000, mk(1'b0, 8'h00, 24'h000000, 1'b1, 1'b1, 8'd4));
`endif
        receive("floor", 0);

        // Floor with negative sign and immediate floor (exp=1)
`ifdef EXP_NORM_DENORM_EN
        send(1, 1'b1, 8'h01, 24'h000F00, mk(1'b1, 8'h00, 24'h000F00, 1'b0, 1'b1, 8'd2));
`else
        send(1, 1'b1, 8'h01, 24'h000F00, mk(1'b1, 8'h00, 24'h000000, 1'b1, 1'b1, 8'd2));
`endif
        receive("floor_imm", 0);

        // Backpressure for 5 cycles, then a back-to-back operand
        send(1, 1'b0, 8'h10, 24'h300000, mk(1'b0, 8'h0E, 24'hC00000, 1'b0, 1'b0, 8'd4));
        receive("bp", 5);
        send(0, 1'b1, 8'h20, 24'h0F0000, mk(1'b1, 8'h1C, 24'hF00000, 1'b0, 1'b0, 8'd6));
        receive("b2b", 0);

        // Assorted operands against the reference model
        for (int t = 0; t < 6; t++) begin
            rs = 1'($urandom_range(0, 1));
            re = 8'($urandom_range(0, 40));
            rm = 24'($urandom) >> $urandom_range(0, 23);
            send(1, rs, re, rm, model(rs, re, rm));
            receive("rand", $urandom_range(0, 2));
        end

        // Asynchronous reset while shifting (k=10, four cycles in)
        send(1, 1'b1, 8'h40, 24'h002000, mk(1'b1, 8'h36, 24'h800000, 1'b0, 1'b0, 8'd12));
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_exp", 32'(out_exp), 32'd0);
        check("arst_mant", 32'(out_mant), 32'd0);
        check("arst_flags", {29'd0, out_sign, out_zero, out_underflow}, 32'd0);
        if (sb.size() > 0) dropped = sb.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_in_ready", 32'(in_ready), 32'd1);
        send(0, 1'b1, 8'h40, 24'h002000, mk(1'b1, 8'h36, 24'h800000, 1'b0, 1'b0, 8'd12));
        receive("after_rst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
